// File: rtl/contador_decada_pkg.sv
// Shared constants for the decade counter: BCD limits, FSM encoding and
// active-low 7-segment patterns ({g,f,e,d,c,b,a}).
package contador_decada_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/decod7seg.sv
// BCD to active-low 7-segment decoder; non-BCD codes blank the digit.
module decod7seg
  import contador_decada_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/contador_decada.sv
// Cascaded BCD up/down counter stepped by rising edges of novo_clock sampled in
// the CLOCK_50 domain. Define CONTADOR_HEX_EN to add the 7-segment hex output.
module contador_decada
  import contador_decada_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 2
)
(
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic                    novo_clock,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    clear,
  input  logic                    up,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    carry_out,
  output logic                    running
`ifdef CONTADOR_HEX_EN
  ,
  output logic [7*NUM_DIGITS-1:0] hex
`endif
);

  logic s1, s2, prev, tick;
  state_t state, state_nxt;
  logic step;
  logic [4*NUM_DIGITS-1:0] digit_nxt;
  logic [NUM_DIGITS:0]     ripple;

  // novo_clock is asynchronous: two-flop synchronizer plus edge detector
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= novo_clock;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign tick = s2 & ~prev;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) state <= ST_STOP;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_STOP: if (start && !stop) state_nxt = ST_RUN;
      ST_RUN:  if (stop)           state_nxt = ST_STOP;
      default:                     state_nxt = ST_STOP;
    endcase
  end

  always_comb begin
    running = (state == ST_RUN);
  end

  assign step = tick & (state == ST_RUN) & ~clear;

  // Ripple chain: ripple[i] enables digit i, ripple[NUM_DIGITS] is the wrap
  always_comb begin
    logic [3:0] cur;
    ripple    = '0;
    ripple[0] = step;
    digit_nxt = bcd;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      cur = bcd[4*i +: 4];
      if (ripple[i]) begin
        if (up) begin
          if (cur >= BCD_MAX) begin
            digit_nxt[4*i +: 4] = BCD_MIN;
            ripple[i+1]         = 1'b1;
          end else begin
            digit_nxt[4*i +: 4] = cur + 4'd1;
          end
        end else begin
          if (cur == BCD_MIN || cur > BCD_MAX) begin
            digit_nxt[4*i +: 4] = BCD_MAX;
            ripple[i+1]         = 1'b1;
          end else begin
            digit_nxt[4*i +: 4] = cur - 4'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) carry_out <= 1'b0;
    else       carry_out <= ripple[NUM_DIGITS];
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    logic [3:0] digit_q;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset)      digit_q <= BCD_MIN;
      else if (clear) digit_q <= BCD_MIN;
      else            digit_q <= digit_nxt[4*g +: 4];
    end

    assign bcd[4*g +: 4] = digit_q;

`ifdef CONTADOR_HEX_EN
    decod7seg u_decod7seg (
      .bcd (digit_q),
      .seg (hex[7*g +: 7])
    );
`endif
  end

endmodule

// File: tb/tb_contador_decada.sv
// Scoreboard bench for contador_decada: each novo_clock pulse queues the
// expected bcd/carry_out, checked 3 CLOCK_50 edges after the rise.
module tb_contador_decada;

  localparam int unsigned ND  = 2;
  localparam int          MOD = 100;

  logic CLOCK_50 = 1'b0;
  logic reset, novo_clock, start, stop, clear, up;
  logic [4*ND-1:0] bcd;
  logic carry_out, running;
`ifdef CONTADOR_HEX_EN
  logic [7*ND-1:0] hex;
`endif

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  int unsigned cyc         = 0;
  int          model_val   = 0;
  bit          model_run   = 1'b0;

  typedef struct {
    int unsigned     due;
    logic [4*ND-1:0] old_v;
    logic [4*ND-1:0] new_v;
    logic            carry;
  } exp_t;

  exp_t sb[$];

  contador_decada #(.NUM_DIGITS(ND)) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .novo_clock (novo_clock),
    .start      (start),
    .stop       (stop),
    .clear      (clear),
    .up         (up),
    .bcd        (bcd),
    .carry_out  (carry_out),
    .running    (running)
`ifdef CONTADOR_HEX_EN
    ,
    .hex        (hex)
`endif
  );

  always #5 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [4*ND-1:0] to_bcd(input int v);
    logic [4*ND-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < int'(ND); i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // One novo_clock pulse; optional start/stop/clear asserted in its tick cycle
  task automatic do_tick(input bit w_start, input bit w_stop, input bit w_clear);
    exp_t e;
    bit   wrap;
    @(negedge CLOCK_50);
    novo_clock = 1'b1;
    e.due   = cyc + 3;
    e.old_v = to_bcd(model_val);
    wrap    = 1'b0;
    if (w_clear) model_val = 0;
    else if (model_run) begin
      if (up) begin
        if (model_val == MOD - 1) begin model_val = 0; wrap = 1'b1; end
        else model_val++;
      end else begin
        if (model_val == 0) begin model_val = MOD - 1; wrap = 1'b1; end
        else model_val--;
      end
    end
    e.new_v = to_bcd(model_val);
    e.carry = wrap;
    sb.push_back(e);
    if (w_stop) model_run = 1'b0;
    else if (w_start) model_run = 1'b1;
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    start = w_start; stop = w_stop; clear = w_clear;
    @(negedge CLOCK_50);
    start = 1'b0; stop = 1'b0; clear = 1'b0; novo_clock = 1'b0;
    @(negedge CLOCK_50);
    check("running_tick", 32'(running), 32'(model_run));
  endtask

  task automatic pulse(input bit s, input bit p, input bit c);
    @(negedge CLOCK_50);
    start = s; stop = p; clear = c;
    if (c) model_val = 0;
    if (p) model_run = 1'b0;
    else if (s) model_run = 1'b1;
    @(negedge CLOCK_50);
    start = 1'b0; stop = 1'b0; clear = 1'b0;
    check("running_ctl", 32'(running), 32'(model_run));
    check("bcd_ctl", 32'(bcd), 32'(to_bcd(model_val)));
  endtask

  always @(posedge CLOCK_50) begin : monitor
    exp_t e;
    #1;
    if (sb.size() != 0 && sb[0].due == cyc + 1)
      check("bcd_hold", 32'(bcd), 32'(sb[0].old_v));
    if (sb.size() != 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      check("bcd_step", 32'(bcd), 32'(e.new_v));
      check("carry_step", 32'(carry_out), 32'(e.carry));
    end else begin
      check("carry_idle", 32'(carry_out), 32'd0);
    end
  end

  initial begin : watchdog
    #500us;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; novo_clock = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; up = 1'b1;
    repeat (6) begin
      @(negedge CLOCK_50);
      novo_clock = ~novo_clock;
    end
    check("rst_bcd", 32'(bcd), 32'd0);
    check("rst_running", 32'(running), 32'd0);
    check("rst_carry", 32'(carry_out), 32'd0);
`ifdef CONTADOR_HEX_EN
    check("rst_hex", 32'(hex), 32'({7'b1000000, 7'b1000000}));
`endif
    @(negedge CLOCK_50);
    reset = 1'b0;
    repeat (3) @(negedge CLOCK_50);

    // basic counting
    pulse(1'b1, 1'b0, 1'b0);
    repeat (12) do_tick(1'b0, 1'b0, 1'b0);
    check("count_12", 32'(bcd), 32'h12);
`ifdef CONTADOR_HEX_EN
    check("hex_12", 32'(hex), 32'({7'b1111001, 7'b0100100}));
`endif

    // up wrap
    repeat (86) do_tick(1'b0, 1'b0, 1'b0);
    check("count_98", 32'(bcd), 32'h98);
    do_tick(1'b0, 1'b0, 1'b0);
    check("count_99", 32'(bcd), 32'h99);
    do_tick(1'b0, 1'b0, 1'b0);
    check("wrap_up", 32'(bcd), 32'h00);

    // down mode
    up = 1'b0;
    do_tick(1'b0, 1'b0, 1'b0);
    check("wrap_down", 32'(bcd), 32'h99);
    up = 1'b1;
    pulse(1'b0, 1'b0, 1'b1);
    repeat (10) do_tick(1'b0, 1'b0, 1'b0);
    check("count_10", 32'(bcd), 32'h10);
    up = 1'b0;
    do_tick(1'b0, 1'b0, 1'b0);
    check("borrow_09", 32'(bcd), 32'h09);

    // stop/start interactions
    pulse(1'b0, 1'b1, 1'b0);
    repeat (5) do_tick(1'b0, 1'b0, 1'b0);
    check("stopped", 32'(bcd), 32'h09);
    pulse(1'b1, 1'b1, 1'b0);
    check("start_stop", 32'(running), 32'd0);
    do_tick(1'b1, 1'b0, 1'b0);
    check("start_tick", 32'(bcd), 32'h09);
    check("start_tick_run", 32'(running), 32'd1);
    do_tick(1'b0, 1'b1, 1'b0);
    check("stop_tick", 32'(bcd), 32'h08);
    check("stop_tick_run", 32'(running), 32'd0);
    pulse(1'b1, 1'b0, 1'b0);

    // clear beats a wrapping tick
    pulse(1'b0, 1'b0, 1'b1);
    do_tick(1'b0, 1'b0, 1'b0);
    check("pre_clear", 32'(bcd), 32'h99);
    up = 1'b1;
    do_tick(1'b0, 1'b0, 1'b1);
    check("clear_tick", 32'(bcd), 32'h00);
    check("clear_run", 32'(running), 32'd1);

    // asynchronous reset mid-count
    pulse(1'b0, 1'b0, 1'b1);
    repeat (47) do_tick(1'b0, 1'b0, 1'b0);
    check("count_47", 32'(bcd), 32'h47);
    @(posedge CLOCK_50);
    #2;
    reset = 1'b1;
    novo_clock = 1'b1;
    #1;
    check("arst_bcd", 32'(bcd), 32'd0);
    check("arst_running", 32'(running), 32'd0);
    model_val = 0;
    model_run = 1'b0;
    @(negedge CLOCK_50);
    reset = 1'b0;
    repeat (4) @(negedge CLOCK_50);
    check("post_rst_level", 32'(bcd), 32'd0);
    novo_clock = 1'b0;
    @(negedge CLOCK_50);
    repeat (3) do_tick(1'b0, 1'b0, 1'b0);
    check("post_rst_idle", 32'(bcd), 32'd0);
    pulse(1'b1, 1'b0, 1'b0);
    do_tick(1'b0, 1'b0, 1'b0);
    check("post_rst_count", 32'(bcd), 32'h01);

    repeat (4) @(negedge CLOCK_50);
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/contador_decada.md
# contador_decada

Decade (BCD) counter stage placed directly downstream of the clock divider. It consumes the divider's slow square wave `novo_clock` as a data input, never as a clock. It synchronizes and edge-detects that input inside the `CLOCK_50` domain and counts one BCD step per rising edge. Start, stop, clear and direction controls are provided, and the count drives the board's 7-segment displays.

## Interface
Parameters:
- `NUM_DIGITS`, default 2: number of cascaded BCD digits (1..8).

Ports:
- `CLOCK_50`  input  1  system clock, 50 MHz; the only clock of the block.
- `reset`  input  1  asynchronous, active-high reset.
- `novo_clock`  input  1  slow square wave from the divider; asynchronous to `CLOCK_50` for design purposes.
- `start`  input  1  one-cycle pulse: begin or resume counting.
- `stop`  input  1  one-cycle pulse: freeze the count.
- `clear`  input  1  synchronous clear of all digits.
- `up`  input  1  direction: 1 counts up, 0 counts down.
- `bcd`  output  4*NUM_DIGITS  count value; digit 0 is the least significant, in bits [3:0].
- `carry_out`  output  1  one-cycle pulse on wrap-around in either direction.
- `running`  output  1  high while the FSM is in RUN.
- `hex`  output  7*NUM_DIGITS  active-low segments {g,f,e,d,c,b,a} per digit. Present only with `CONTADOR_HEX_EN`.

## Operation
- **Synchronizer:** `novo_clock` passes through flops s1 then s2. A third flop `prev` holds the previous s2.
- **Tick:** `tick = s2 & ~prev`. It is high for exactly one `CLOCK_50` cycle per rising edge of `novo_clock`.
- **FSM states:** STOP (reset state) and RUN.
  - STOP -> RUN when `start` is 1 and `stop` is 0.
  - RUN -> STOP when `stop` is 1.
  - `start` and `stop` both high: `stop` wins. The result is STOP from either state.
  - `running` = (state == RUN).
- **Count step:** a step occurs on a cycle with `tick` = 1, state RUN and `clear` = 0.
  - Up: digit 0 increments. A digit at 9 becomes 0 and carries into the next digit.
  - Down: digit 0 decrements. A digit at 0 becomes 9 and borrows from the next digit.
  - `up` is sampled in the tick cycle.
- **Wrap:**
  - Up from all-9s gives all-0s; down from all-0s gives all-9s.
  - `carry_out` = 1 in the cycle the wrapped value is registered, otherwise 0.
- **Clear:** `clear` = 1 sets `bcd` to 0 on the next edge, regardless of state or `tick`.
  - Clear wins over a simultaneous step; `carry_out` stays 0.
  - The FSM state is unchanged.
- **Digit range:** digits only ever hold values 0..9.
- **Reset:** asserting `reset` at any time immediately forces:
  - `bcd` = 0, `carry_out` = 0, `running` = 0, state STOP;
  - s1, s2 and `prev` = 0;
  - every `hex` digit = 7'b1000000 ("0").

## Timing
- **Tick latency:** `novo_clock` rises before edge k; s1 = 1 at k, s2 = 1 at k+1, `tick` is high in the cycle after k+1, and `bcd` updates at edge k+2.
  - This gives 3 `CLOCK_50` edges from the `novo_clock` rise to the new `bcd`.
- **Control latency:** `start`, `stop` and `clear` take effect at the first edge at which they are sampled high. `running` changes at that same edge.
- **Start and tick together:** a tick in the same cycle as `start` (state still STOP) is ignored.
- **Stop and tick together:** a tick in the same cycle as `stop` while in RUN is counted. The state is still RUN during that cycle; STOP applies from the next edge.
- **After reset release:** a `novo_clock` level that is already high may produce a tick. It is ignored because the state is STOP.
- **Display timing:** `hex` is combinational from `bcd`, with no added latency.

## Configuration
- **Macro:** `CONTADOR_HEX_EN`.
- **Defined:** the `hex` port exists, with one `decod7seg` instance per digit.
  - Patterns, active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- **Undefined:** no `hex` port and no decoders; counting behaviour is identical.

## Structure
- **Shared package / include file:**
  - BCD constants `BCD_MAX` = 4'd9 and `BCD_MIN` = 4'd0;
  - FSM state encodings ST_STOP = 1'b0 and ST_RUN = 1'b1;
  - the ten segment patterns.
- **Sub-module:** `decod7seg` (4-bit BCD in, 7-bit active-low out), combinational.
- **Top-level logic:** synchronizer, edge detector, FSM and the digit-chain generate loop stay in `contador_decada`.

## Test plan
1. **Reset and basic counting.** Hold `reset` with `novo_clock` toggling, then release it.
   - Expect `bcd` = 00, `running` = 0 and `hex` = 1000000 on both digits.
   - Pulse `start`, then give 12 rising edges → `bcd` = 0x12.
   - Each update lands 3 edges after its `novo_clock` rise.
2. **Up wrap.** Start at 0x98 in RUN with `up` = 1 and apply 2 ticks.
   - Expect `bcd` = 0x99, then 0x00.
   - `carry_out` is high for exactly one cycle, coincident with the 0x00 update.
3. **Down mode.** In RUN with `up` = 0, starting from 0x10: one tick gives 0x09; from 0x00, one tick gives 0x99 with a `carry_out` pulse.
4. **Stop, start and their interaction with ticks.**
   - `stop` then 5 ticks → `bcd` unchanged.
   - `start` and `stop` in the same cycle → `running` = 0.
   - `start` coincident with a tick → that tick is not counted.
5. **Clear.** Assert `clear` in the same cycle as a tick at 0x99 with `up` = 1.
   - Expect `bcd` = 0x00, `carry_out` = 0 and `running` still 1.
6. **Reset mid-count.** Assert `reset` asynchronously (off-edge) at 0x47 in RUN.
   - `bcd` = 00 and `running` = 0 immediately.
   - After release, ticks do not count until `start`.
